// File: rtl/dram_seq.sv
// DRAM slot sequencer: video/CPU arbitration with RAS/CAS strobes.
// Define DRAM_SEQ_REFRESH_EN to add RAS-only refresh every REFRESH_SLOTS slots.
module dram_seq #(
  parameter int unsigned REFRESH_SLOTS = 64
) (
  input  logic        clk,
  input  logic        res,
  input  logic        slot,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  input  logic [15:0] ram_din,
  output logic [15:0] ram_dout,
  output logic [9:0]  ma,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [15:0] rdata,
  output logic [9:0]  refresh_cnt
);

  typedef enum logic [2:0] {
    IDLE, S1, S2, S3, PRE
  } state_e;

  typedef enum logic [1:0] {
    G_NONE, G_REF, G_VID, G_CPU
  } grant_e;

  if (REFRESH_SLOTS < 2 || REFRESH_SLOTS > 255) begin : g_bad_slots
    $error("REFRESH_SLOTS must be in 2..255");
  end

  state_e      state_q, state_d;
  grant_e      grant_q, grant_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] din_q, din_d;
  logic [9:0]  mah_q, mah_d;
  logic [15:0] rdata_q, rdata_d;
  logic        accept;
  logic        active;
  logic        ref_pend;

  assign accept = slot && (state_q == IDLE || state_q == PRE);
  assign active = (state_q == S1) || (state_q == S2) || (state_q == S3);

`ifdef DRAM_SEQ_REFRESH_EN
  localparam logic [7:0] LAST = 8'(REFRESH_SLOTS - 1);

  logic [7:0] scnt_q, scnt_d;
  logic       pend_q, pend_d;
  logic [9:0] rcnt_q, rcnt_d;

  // Expiry is applied after the acceptance clear so it wins on a tie.
  always_comb begin
    scnt_d = scnt_q;
    pend_d = pend_q;
    rcnt_d = rcnt_q;
    if (accept && pend_q) pend_d = 1'b0;
    if (slot) begin
      if (scnt_q == LAST) begin
        scnt_d = '0;
        pend_d = 1'b1;
      end else begin
        scnt_d = scnt_q + 8'd1;
      end
    end
    if (state_q == S3 && grant_q == G_REF) rcnt_d = rcnt_q + 10'd1;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      scnt_q <= '0;
      pend_q <= 1'b0;
      rcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      pend_q <= pend_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign ref_pend    = pend_q;
  assign refresh_cnt = rcnt_q;
`else
  assign ref_pend    = 1'b0;
  assign refresh_cnt = '0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    din_d   = din_q;
    mah_d   = mah_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S1: state_d = S2;
      S2: state_d = S3;
      S3: begin
        state_d = PRE;
        mah_d   = ma;
        if ((grant_q == G_VID || grant_q == G_CPU) && !we_q)
          rdata_d = ram_din;
      end
      IDLE, PRE: begin
        state_d = IDLE;
        if (accept) begin
          state_d = S1;
          we_d    = 1'b0;
          din_d   = '0;
          if (ref_pend) begin
            grant_d = G_REF;
          end else if (vid_req) begin
            grant_d = G_VID;
            addr_d  = vid_addr;
          end else if (cpu_req) begin
            grant_d = G_CPU;
            addr_d  = cpu_addr;
            we_d    = cpu_we;
            din_d   = cpu_din;
          end else begin
            grant_d = G_NONE;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      mah_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      mah_q   <= mah_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ma = mah_q;
    if (active) begin
      if (grant_q == G_REF)   ma = refresh_cnt;
      else if (state_q == S1) ma = addr_q[19:10];
      else                    ma = addr_q[9:0];
    end
  end

  assign ras_n    = ~active;
  assign cas_n    = ~(state_q == S3 && grant_q != G_REF);
  assign we_n     = ~((state_q == S2 || state_q == S3) &&
                      grant_q == G_CPU && we_q);
  assign ram_dout = (active && grant_q == G_CPU && we_q) ? din_q : '0;
  assign vid_ack  = (state_q == S3) && (grant_q == G_VID);
  assign cpu_ack  = (state_q == S3) && (grant_q == G_CPU);
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dram_seq.sv
// Bench for dram_seq: slot-timeline reference model plus directed
// literal checks, random slots/requests/resets and a refresh wrap run.
module tb_dram_seq;

  localparam int unsigned RS = 2;
`ifdef DRAM_SEQ_REFRESH_EN
  localparam bit REF_ON = 1'b1;
`else
  localparam bit REF_ON = 1'b0;
`endif
  localparam int K_REF = 0;
  localparam int K_VID = 1;
  localparam int K_CPU = 2;

  logic        clk = 1'b0;
  logic        res, slot, vid_req, cpu_req, cpu_we;
  logic [19:0] vid_addr, cpu_addr;
  logic [15:0] cpu_din, ram_din, ram_dout, rdata;
  logic        vid_ack, cpu_ack, ras_n, cas_n, we_n;
  logic [9:0]  ma, refresh_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int vacks  = 0;

  dram_seq #(.REFRESH_SLOTS(RS)) dut (
    .clk(clk), .res(res), .slot(slot),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .ram_din(ram_din), .ram_dout(ram_dout), .ma(ma),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .rdata(rdata), .refresh_cnt(refresh_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  // Model: an access occupies the three clocks after its accepting edge.
  int unsigned m_cyc, m_acc;
  bit          m_have, m_we, m_pend;
  int          m_kind, m_scnt;
  logic [19:0] m_addr;
  logic [15:0] m_din, m_rdata;
  logic [9:0]  m_lastma, m_rf;

  always @(posedge clk or posedge res) begin : model
    int unsigned k;
    bit          acc, p;
    logic [9:0]  rf;
    if (res) begin
      m_cyc <= 0; m_acc <= 0; m_have <= 0; m_we <= 0;
      m_pend <= 0; m_kind <= 0; m_scnt <= 0; m_addr <= 0;
      m_din <= 0; m_rdata <= 0; m_lastma <= 0; m_rf <= 0;
    end else begin
      k  = m_cyc - m_acc;
      rf = m_rf;
      if (m_have && k == 2) begin
        m_lastma <= (m_kind == K_REF) ? m_rf :
                    m_addr[9:0];
        if (m_kind == K_REF) rf = m_rf + 10'd1;
        else if (!(m_kind == K_CPU && m_we)) m_rdata <= ram_din;
      end
      m_rf <= REF_ON ? rf : 10'd0;
      acc = slot && (!m_have || k >= 3);
      if (acc) begin
        m_acc  <= m_cyc + 1;
        m_have <= 1;
        m_we   <= 0;
        m_din  <= 0;
        if (REF_ON && m_pend) begin
          m_kind <= K_REF;
        end else if (vid_req) begin
          m_kind <= K_VID; m_addr <= vid_addr;
        end else if (cpu_req) begin
          m_kind <= K_CPU; m_addr <= cpu_addr;
          m_we <= cpu_we; m_din <= cpu_din;
        end else begin
          m_have <= 0;
        end
      end
      p = m_pend;
      if (acc && m_pend) p = 0;
      if (REF_ON && slot) begin
        if (m_scnt == int'(RS) - 1) begin
          m_scnt <= 0; p = 1;
        end else begin
          m_scnt <= m_scnt + 1;
        end
      end
      m_pend <= REF_ON ? p : 1'b0;
      m_cyc  <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int unsigned k;
    bit          ia, wr;
    logic [9:0]  ema;
    k  = m_cyc - m_acc;
    ia = m_have && (k <= 2);
    wr = ia && m_kind == K_CPU && m_we;
    if (!ia)                 ema = m_lastma;
    else if (m_kind == K_REF) ema = m_rf;
    else if (k == 0)          ema = m_addr[19:10];
    else                      ema = m_addr[9:0];
    chk("ras_n", 32'(ras_n), 32'(!ia));
    chk("cas_n", 32'(cas_n), 32'(!(ia && k == 2 && m_kind != K_REF)));
    chk("we_n", 32'(we_n), 32'(!(wr && k >= 1)));
    chk("ma", 32'(ma), 32'(ema));
    chk("ram_dout", 32'(ram_dout), wr ? 32'(m_din) : 32'd0);
    chk("vid_ack", 32'(vid_ack), 32'(ia && k == 2 && m_kind == K_VID));
    chk("cpu_ack", 32'(cpu_ack), 32'(ia && k == 2 && m_kind == K_CPU));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("refresh_cnt", 32'(refresh_cnt), 32'(m_rf));
    if (vid_ack === 1'b1) vacks++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick(2);
    res = 1'b0;
  endtask

  initial begin
    int v0;
    res = 1'b1; slot = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr = 0; cpu_addr = 0; cpu_din = 0; ram_din = 0;
    tick(3);
    @(negedge clk);
    chk("rst_ras_n", 32'(ras_n), 32'd1);
    chk("rst_ma", 32'(ma), 32'd0);
    tick(1);
    res = 1'b0;

    // CPU read of 0xABCDE
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'hABCDE; ram_din = 16'h1234;
    slot = 1; tick(1); slot = 0;
    @(negedge clk); chk("rd_row", 32'(ma), 32'h2AF);
    tick(1);
    @(negedge clk); chk("rd_col", 32'(ma), 32'h0DE);
    chk("rd_cas_s2", 32'(cas_n), 32'd1);
    tick(1);
    @(negedge clk); chk("rd_cas_s3", 32'(cas_n), 32'd0);
    chk("rd_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 0;
    tick(1);
    @(negedge clk); chk("rd_data", 32'(rdata), 32'h1234);
    chk("rd_ack_off", 32'(cpu_ack), 32'd0);

    // Reset during S2 of a read, then re-serve
    cpu_req = 1; cpu_addr = 20'h12345;
    slot = 1; tick(1); slot = 0;
    tick(1);
    res = 1'b1; #1;
    chk("abort_ras_n", 32'(ras_n), 32'd1);
    chk("abort_rdata", 32'(rdata), 32'd0);
    tick(2);
    res = 1'b0;
    slot = 1; tick(1); slot = 0;
    @(negedge clk); chk("reserve_ras", 32'(ras_n), 32'd0);
    chk("reserve_row", 32'(ma), 32'h048);
    tick(2);
    @(negedge clk); chk("reserve_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 0;
    tick(1);

    // CPU write of 0xBEEF to word 1
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00001; cpu_din = 16'hBEEF;
    slot = 1; tick(1); slot = 0; cpu_din = 16'h0000;
    @(negedge clk); chk("wr_row", 32'(ma), 32'h000);
    chk("wr_we_s1", 32'(we_n), 32'd1);
    tick(1);
    @(negedge clk); chk("wr_col", 32'(ma), 32'h001);
    chk("wr_we_s2", 32'(we_n), 32'd0);
    chk("wr_dout", 32'(ram_dout), 32'hBEEF);
    tick(1);
    @(negedge clk); chk("wr_we_s3", 32'(we_n), 32'd0);
    cpu_req = 0; cpu_we = 0;
    tick(1);
    @(negedge clk); chk("wr_rdata", 32'(rdata), 32'h1234);
    chk("wr_dout_off", 32'(ram_dout), 32'd0);

    // Video over CPU, CPU after video drops
    do_reset();
    vid_req = 1; vid_addr = 20'hF00F0; cpu_req = 1; cpu_addr = 20'h11111;
    slot = 1; tick(1); slot = 0;
    @(negedge clk); chk("vid_row", 32'(ma), 32'h3C0);
    tick(2);
    @(negedge clk); chk("vid_ack_s3", 32'(vid_ack), 32'd1);
    chk("vid_cpu_ack", 32'(cpu_ack), 32'd0);
    vid_req = 0;
    tick(1);
    slot = 1; tick(1); slot = 0;
    tick(2);
    @(negedge clk); chk("cpu_after_vid", 32'(cpu_ack), 32'd1);
    cpu_req = 0;
    tick(2);

    // Random traffic: regular slots first, then random slot timing
    for (int i = 0; i < 3000; i++) begin
      if (i < 1200) slot = (i % 4 == 0);
      else slot = !slot && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) vid_req = ~vid_req;
      if ($urandom_range(0, 5) == 0) cpu_req = ~cpu_req;
      cpu_we   = 1'($urandom_range(0, 1));
      vid_addr = 20'($urandom);
      cpu_addr = 20'($urandom);
      cpu_din  = 16'($urandom);
      ram_din  = 16'($urandom);
      res      = (i > 1200) && ($urandom_range(0, 249) == 0);
      tick(1);
    end
    res = 0; slot = 0;

    // Refresh counter wrap with video always requesting
    do_reset();
    vid_req = 1; cpu_req = 1; cpu_we = 0;
    v0 = vacks;
    for (int s = 0; s < 2051; s++) begin
      ram_din = 16'($urandom);
      slot = 1; tick(1); slot = 0; tick(3);
    end
    vid_req = 0; cpu_req = 0;
    tick(8);
    @(negedge clk);
    chk("wrap_refresh_cnt", 32'(refresh_cnt), REF_ON ? 32'd1 : 32'd0);
    chk("wrap_vid_acks", 32'(vacks - v0), REF_ON ? 32'd1026 : 32'd2051);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_seq.md
DRAM_SEQ -- requirements
Module: dram_seq

Interface
REQ-001 Parameter REFRESH_SLOTS, default 64: number of slot pulses between refresh requests (range 2..255).
REQ-002 Ports, in order: clk in 1 system clock (all logic on rising edge); res in 1 asynchronous reset, active-high; slot in 1 one-clk pulse marking the start of each 4-clk memory slot, generated upstream from the clock generator phases; vid_req in 1 video fetch request (level); vid_addr in 20 video word address; vid_ack out 1 video grant/data strobe; cpu_req in 1 CPU request (level); cpu_we in 1 CPU write; cpu_addr in 20 CPU word address; cpu_din in 16 write data; cpu_ack out 1 CPU completion strobe; ram_din in 16 DRAM read data; ram_dout out 16 DRAM write data; ma out 10 multiplexed DRAM address; ras_n out 1; cas_n out 1; we_n out 1; rdata out 16 latched read data; refresh_cnt out 10 current refresh row.

Function
REQ-003 States: IDLE, S1 (row), S2 (column), S3 (strobe), PRE (precharge); transitions PRE->IDLE unless a slot is accepted.
REQ-004 A slot pulse is accepted only in IDLE or PRE; accepted -> S1 next clk; slot in S1/S2/S3 ignored, no state change.
REQ-005 At acceptance the grant is fixed by priority: refresh pending > vid_req > cpu_req; no request -> stay/return IDLE, outputs inactive.
REQ-006 Granted address and cpu_we/cpu_din are registered at acceptance; later input changes do not affect the cycle.
REQ-007 S1: ras_n=0, ma=addr[19:10]; S2: ras_n=0, ma=addr[9:0], we_n=~cpu_we for CPU grant else 1; S3: ras_n=0, cas_n=0, ma and we_n held.
REQ-008 PRE and IDLE: ras_n=1, cas_n=1, we_n=1, ma holds last value.
REQ-009 ram_dout = registered cpu_din while a CPU write is granted, else 0.
REQ-010 Read grants: rdata loaded from ram_din on the S3->next edge; valid from the first clk after S3 until the next read completes.
REQ-011 vid_ack / cpu_ack: high exactly during S3 of the matching grant, one clk wide; requester drops or renews its req by the next slot.
REQ-012 Refresh grant is RAS-only: S1..S3 ras_n=0, ma=refresh_cnt, cas_n=1, we_n=1, no ack.
REQ-013 Slot counter counts accepted-or-not slot pulses; at REFRESH_SLOTS it wraps to 0 and sets refresh pending; pending already set stays set (no accumulation).
REQ-014 Pending clears at refresh acceptance; refresh_cnt increments at end of S3 of each refresh, wrapping 1023->0.
REQ-015 Slot counter expiry coinciding with refresh acceptance: pending cleared, then set again (expiry wins).
REQ-016 Back-to-back: slot every 4 clks gives continuous S1,S2,S3,PRE sequence with no IDLE cycle.

Reset
REQ-017 While res=1, asynchronously: state IDLE, ras_n=cas_n=we_n=1, ma=0, ram_dout=0, rdata=0, vid_ack=cpu_ack=0, refresh_cnt=0, slot counter=0, pending=0.
REQ-018 Reset mid-cycle aborts the access: no ack, no rdata update, no refresh_cnt increment.
REQ-019 First slot pulse on the clk after res falls is accepted normally.

Configuration
REQ-020 Macro DRAM_SEQ_REFRESH_EN: defined -> REQ-012..REQ-015 apply; undefined -> slot counter, pending flag and refresh increment absent, refresh_cnt tied 0, arbitration video > CPU only.

Verification
REQ-021 Reset, slot every 4 clks, no requests -> ras_n/cas_n stay 1 until first refresh at slot 64 (macro on); refresh_cnt 0->1.
REQ-022 cpu_req=1, cpu_we=0, cpu_addr=0xABCDE, ram_din=0x1234 -> ma=0x2AF then 0x0DE, cas_n low one clk, cpu_ack one clk in S3, rdata=0x1234 next clk.
REQ-023 vid_req and cpu_req both high -> video granted first (vid_ack), CPU granted on next slot after vid_req drops.
REQ-024 CPU write cpu_addr=0x00001, cpu_din=0xBEEF -> we_n=0 during S2..S3, ram_dout=0xBEEF, rdata unchanged.
REQ-025 Assert res during S2 of a CPU read -> ras_n=1 immediately, no cpu_ack, rdata=0; next slot after release re-serves request.
REQ-026 1024 refreshes forced with REFRESH_SLOTS=2 -> refresh_cnt wraps 1023->0; pending with vid_req active -> refresh wins.
